hex_field_overlay: RTL and testbench

Downstream consumer of the 5x7 hex glyph engine. It holds NUM_FIELDS 32-bit values written by the system and maps the engine's character-cell coordinates (char_x, char_y) and 16-wide glyph pixel vector (char_data) to a single overlay pixel, so each value renders as 8 hex digits on its own text row. Values are double-buffered and committed on the vsync rising edge, so a frame never shows a half-updated field.

---
 rtl/hex_field_overlay_pkg.sv | 22 ++
 rtl/hex_field_overlay_if.sv | 18 +
 rtl/hex_field_overlay_bank.sv | 59 +++++
 rtl/hex_field_overlay.sv | 88 ++++++++
 tb/tb_hex_field_overlay.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/hex_field_overlay_pkg.sv
// Shared widths, the field type and the nibble-select helper
// for the hex field overlay.
package hex_overlay_pkg;

    localparam int FIELD_W = 32;
    localparam int DIGITS  = 8;
    localparam int GLYPHS  = 16;
    localparam int NIB_W   = 4;

    typedef logic [FIELD_W-1:0] field_t;

    // dx = 0 selects the most significant hex digit
    function automatic logic [NIB_W-1:0] get_nib(
        input field_t     f,
        input logic [2:0] dx
    );
        field_t s;
        s = f >> {3'd7 - dx, 2'b00};
        return s[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/hex_field_overlay_if.sv
// Field write bus: strobe, field index and 32-bit value.
// Master is the system writer, slave is the overlay.
interface hex_field_overlay_if
    import hex_overlay_pkg::*;
#(
    parameter int NUM_FIELDS = 8
);

    localparam int AW = $clog2(NUM_FIELDS);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    field_t        wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/hex_field_overlay_bank.sv
// Double-buffered field bank: shadow/active/pending arrays,
// vsync rising-edge commit and an active-bank read port.
module hex_field_bank
    import hex_overlay_pkg::*;
#(
    parameter int NUM_FIELDS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    hex_field_overlay_if.slave            wr,
    input  logic                          vsync_i,
    input  logic [$clog2(NUM_FIELDS)-1:0] rd_addr_i,
    output field_t                        rd_data_o,
    output logic                          commit_o
);

    field_t                shadow_q [NUM_FIELDS];
    field_t                active_q [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] pending_q;
    logic                  vsync_q;
    logic                  commit_q;
    logic                  rise;
    logic                  wr_ok;

    assign rise  = vsync_i & ~vsync_q;
    assign wr_ok = wr.wr_en && (int'(wr.wr_addr) < NUM_FIELDS);

    // Commit pending fields on vsync rise; a same-cycle write
    // lands in shadow after the copy and re-arms pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pending_q <= '0;
            vsync_q   <= 1'b1;
            commit_q  <= 1'b0;
        end else begin
            vsync_q  <= vsync_i;
            commit_q <= rise;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (rise && pending_q[i]) begin
                    active_q[i]  <= shadow_q[i];
                    pending_q[i] <= 1'b0;
                end
            end
            if (wr_ok) begin
                shadow_q[wr.wr_addr]  <= wr.wr_data;
                pending_q[wr.wr_addr] <= 1'b1;
            end
        end
    end

    assign rd_data_o = (int'(rd_addr_i) < NUM_FIELDS)
                     ? active_q[rd_addr_i] : '0;
    assign commit_o  = commit_q;

endmodule

// File: rtl/hex_field_overlay.sv
// Maps glyph-engine cell coordinates and glyph pixels to one
// overlay pixel, rendering each field as 8 hex digits per row.
module hex_field_overlay
    import hex_overlay_pkg::*;
#(
    parameter int NUM_FIELDS = 8,
    parameter int ROW0       = 2,
    parameter int COL0       = 4
) (
    input  logic              clk,
    input  logic              reset,
    hex_field_overlay_if.slave wr,
    input  logic              vsync,
    input  logic              blank,
    input  logic [7:0]        char_x,
    input  logic [7:0]        char_y,
    input  logic [GLYPHS-1:0] char_data,
    output logic              pix_on,
    output logic              box_on,
    output logic              blank_out,
    output logic              commit
);

    localparam int AW = $clog2(NUM_FIELDS);

    logic [8:0]       dy;
    logic [8:0]       dx;
    logic             hit;
    field_t           rd_data;

    logic             hit_q, hit_d;
    logic [NIB_W-1:0] nib_q, nib_d;
    logic             blank_q, blank_d;
    logic             pix_q, pix_d;
    logic             box_q, box_d;
    logic             blk_q, blk_d;

    // 9-bit differences so cells left of / above the box wrap high
    assign dy  = {1'b0, char_y} - 9'(ROW0);
    assign dx  = {1'b0, char_x} - 9'(COL0);
    assign hit = (dy < 9'(NUM_FIELDS)) && (dx < 9'(DIGITS));

    hex_field_bank #(
        .NUM_FIELDS (NUM_FIELDS)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .vsync_i   (vsync),
        .rd_addr_i (dy[AW-1:0]),
        .rd_data_o (rd_data),
        .commit_o  (commit)
    );

    // Stage 1 picks the digit; stage 2 looks it up in char_data
    always_comb begin
        hit_d   = hit;
        nib_d   = get_nib(rd_data, dx[2:0]);
        blank_d = blank;
        pix_d   = hit_q & char_data[nib_q] & ~blank_q;
        box_d   = hit_q & ~blank_q;
        blk_d   = blank_q;
    end

    // Two-stage pixel pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q   <= 1'b0;
            nib_q   <= '0;
            blank_q <= 1'b1;
            pix_q   <= 1'b0;
            box_q   <= 1'b0;
            blk_q   <= 1'b1;
        end else begin
            hit_q   <= hit_d;
            nib_q   <= nib_d;
            blank_q <= blank_d;
            pix_q   <= pix_d;
            box_q   <= box_d;
            blk_q   <= blk_d;
        end
    end

    assign pix_on    = pix_q;
    assign box_on    = box_q;
    assign blank_out = blk_q;

endmodule

// File: tb/tb_hex_field_overlay.sv
// Directed bench for hex_field_overlay with a reference field
// model and an expected-output queue.
module tb_hex_field_overlay;

    localparam int NF   = 8;
    localparam int ROW0 = 2;
    localparam int COL0 = 4;
    localparam int AW   = $clog2(NF);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        blank = 1'b1;
    logic [7:0]  char_x = '0;
    logic [7:0]  char_y = '0;
    logic [15:0] char_data = '0;
    logic        pix_on, box_on, blank_out, commit;

    hex_field_overlay_if #(.NUM_FIELDS(NF)) wr_if ();

    hex_field_overlay #(
        .NUM_FIELDS (NF),
        .ROW0       (ROW0),
        .COL0       (COL0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr_if),
        .vsync     (vsync),
        .blank     (blank),
        .char_x    (char_x),
        .char_y    (char_y),
        .char_data (char_data),
        .pix_on    (pix_on),
        .box_on    (box_on),
        .blank_out (blank_out),
        .commit    (commit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pix;
        logic box;
        logic blk;
        logic cm;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    logic [31:0] m_shadow [NF];
    logic [31:0] m_active [NF];
    logic        m_pend   [NF];
    logic        m_vs_d1;

    logic        p_valid = 1'b0;
    logic        p_hit;
    logic        p_blank;
    logic [3:0]  p_nib;

    task automatic model_clear();
        for (int i = 0; i < NF; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
            m_pend[i]   = 1'b0;
        end
        m_vs_d1 = 1'b1;
    endtask

    task automatic cycle(input int x, input int y, input logic bl,
                         input logic vs, input logic we,
                         input logic [AW-1:0] wa,
                         input logic [31:0] wd);
        exp_t        e;
        exp_t        got;
        logic [8:0]  dy;
        logic [8:0]  dx;
        logic [31:0] f;
        logic        rise;
        @(negedge clk);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {pix_on, box_on, blank_out, commit};
            vectors++;
            assert (got === e) else begin
                miscompares++;
                $error("FAIL px_c%0d pix/box/blk/cm got=%b want=%b",
                       cyc, got, e);
            end
        end
        rise = vs & ~m_vs_d1;
        if (p_valid) begin
            if (cyc % 2 == 0) char_data = 16'h1 << p_nib;
            else              char_data = 16'($urandom);
            e.pix = p_hit & char_data[p_nib] & ~p_blank;
            e.box = p_hit & ~p_blank;
            e.blk = p_blank;
            e.cm  = rise;
            sb.push_back(e);
        end
        dy      = 9'(y) - 9'(ROW0);
        dx      = 9'(x) - 9'(COL0);
        p_hit   = (int'(dy) < NF) && (int'(dx) < 8);
        f       = p_hit ? m_active[dy[AW-1:0]] : 32'h0;
        p_nib   = 4'(f >> (28 - 4 * int'(dx[2:0])));
        p_blank = bl;
        p_valid = 1'b1;
        m_vs_d1 = vs;
        if (rise) begin
            for (int i = 0; i < NF; i++) begin
                if (m_pend[i]) begin
                    m_active[i] = m_shadow[i];
                    m_pend[i]   = 1'b0;
                end
            end
        end
        if (we && int'(wa) < NF) begin
            m_shadow[wa] = wd;
            m_pend[wa]   = 1'b1;
        end
        char_x         = 8'(x);
        char_y         = 8'(y);
        blank          = bl;
        vsync          = vs;
        wr_if.wr_en    = we;
        wr_if.wr_addr  = wa;
        wr_if.wr_data  = wd;
        cyc++;
    endtask

    task automatic do_reset();
        exp_t got;
        @(negedge clk);
        reset       = 1'b1;
        vsync       = 1'b1;
        blank       = 1'b0;
        char_x      = 8'(COL0);
        char_y      = 8'(ROW0);
        wr_if.wr_en = 1'b0;
        @(negedge clk);
        got = {pix_on, box_on, blank_out, commit};
        vectors++;
        assert (got === 4'b0010) else begin
            miscompares++;
            $error("FAIL reset_state got=%b want=0010", got);
        end
        sb.delete();
        p_valid = 1'b0;
        model_clear();
        reset = 1'b0;
    endtask

    task automatic vsync_pulse();
        cycle(0, 0, 1'b1, 1'b1, 1'b0, '0, '0);
        cycle(0, 0, 1'b1, 1'b1, 1'b0, '0, '0);
        cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic scan(input int wr_at, input logic [AW-1:0] wa,
                        input logic [31:0] wd);
        int idx;
        idx = 0;
        for (int r = ROW0 - 1; r <= ROW0 + NF; r++) begin
            for (int c = COL0 - 1; c <= COL0 + 8; c++) begin
                cycle(c, r, 1'b0, 1'b0, idx == wr_at, wa, wd);
                idx++;
            end
            cycle(0, r, 1'b1, 1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        wr_if.wr_en   = 1'b0;
        wr_if.wr_addr = '0;
        wr_if.wr_data = '0;
        model_clear();

        do_reset();
        vsync_pulse();
        scan(-1, '0, '0);
        vsync_pulse();
        scan(-1, '0, '0);

        scan(30, 3'd0, 32'hDEADBEEF);
        vsync_pulse();
        scan(-1, '0, '0);

        cycle(0, 0, 1'b1, 1'b0, 1'b1, 3'd3, 32'h1);
        cycle(0, 0, 1'b1, 1'b0, 1'b1, 3'd3, 32'h2);
        vsync_pulse();
        scan(-1, '0, '0);
        vsync_pulse();
        scan(-1, '0, '0);

        cycle(0, 0, 1'b1, 1'b0, 1'b1, 3'd5, 32'hA5A5_0F0F);
        cycle(0, 0, 1'b1, 1'b1, 1'b1, 3'd5, 32'h1234_5678);
        cycle(0, 0, 1'b1, 1'b1, 1'b0, '0, '0);
        cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, '0);
        scan(-1, '0, '0);
        vsync_pulse();
        scan(-1, '0, '0);

        cycle(0,        ROW0, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle(255,      ROW0, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle(COL0,     0,    1'b0, 1'b0, 1'b0, '0, '0);
        cycle(COL0,     255,  1'b0, 1'b0, 1'b0, '0, '0);
        cycle(COL0 + 7, ROW0 + NF - 1, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle(COL0,     ROW0, 1'b1, 1'b0, 1'b0, '0, '0);

        for (int c = COL0; c < COL0 + 8; c++)
            cycle(c, ROW0, 1'b0, 1'b0, 1'b0, '0, '0);
        do_reset();
        vsync_pulse();
        scan(-1, '0, '0);

        cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, '0);
        cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, '0);
        cycle(0, 0, 1'b1, 1'b0, 1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
